// File: rtl/div_unit_pkg.sv
// Shared defines and types for the iterative divider: operand width, FSM state
// encodings, funct3[1:0] operation codes, and a conditional-negate helper.
`ifndef ARVI_DEFINES_VH
`define ARVI_DEFINES_VH
`define XLEN        32
`define DIV_ST_IDLE 2'd0
`define DIV_ST_CALC 2'd1
`define DIV_ST_DONE 2'd2
`define OP_DIV      2'b00
`define OP_DIVU     2'b01
`define OP_REM      2'b10
`define OP_REMU     2'b11
`endif

package div_unit_pkg;

    localparam int XLEN = `XLEN;

    typedef enum logic [1:0] {
        ST_IDLE = `DIV_ST_IDLE,
        ST_CALC = `DIV_ST_CALC,
        ST_DONE = `DIV_ST_DONE
    } div_state_e;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and keep the difference only if it did not go negative.
module div_step
    import div_unit_pkg::*;
(
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] div,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] diff_s;

    // Trial subtraction; bit XLEN of the difference is the borrow.
    always_comb begin
        shifted_s = {rem[XLEN-1:0], quo[XLEN-1]};
        diff_s    = shifted_s - {1'b0, div};
        if (diff_s[XLEN]) begin
            rem_next = shifted_s;
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = diff_s;
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RISC-V M-extension divider (DIV/DIVU/REM/REMU): 32 restoring
// iterations on magnitudes, with divide-by-zero and signed overflow short-cut.
module div_unit
    import div_unit_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_res
);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    div_state_e      state_r;
    logic [4:0]      cnt_r;
    logic [1:0]      op_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic [XLEN:0]   rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] div_r;
    logic            o_valid_r;
    logic [XLEN-1:0] o_res_r;

    logic            is_signed_s;
    logic            neg_a_s;
    logic            neg_b_s;
    logic            div_zero_s;
    logic            overflow_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic [XLEN:0]   rem_next_s;
    logic [XLEN-1:0] quo_next_s;
    logic [XLEN-1:0] res_fin_s;

    div_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .div      (div_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // Request decode: sign flags, magnitudes and the two short-cut cases.
    always_comb begin
        is_signed_s = ~i_op[0];
        neg_a_s     = is_signed_s & i_rs1[XLEN-1];
        neg_b_s     = is_signed_s & i_rs2[XLEN-1];
        mag_a_s     = neg_if(neg_a_s, i_rs1);
        mag_b_s     = neg_if(neg_b_s, i_rs2);
        div_zero_s  = (i_rs2 == ZERO);
        overflow_s  = is_signed_s && (i_rs1 == INT_MIN) && (i_rs2 == ALL_ONES);
    end

    // Final sign fix-up applied to the last iteration's outputs.
    always_comb begin
        if (op_r[1]) begin
            res_fin_s = neg_if(neg_r_r, rem_next_s[XLEN-1:0]);
        end else begin
            res_fin_s = neg_if(neg_q_r, quo_next_s);
        end
    end

    // Control FSM, iteration counter, datapath registers and result register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 5'd0;
            op_r      <= 2'b00;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            rem_r     <= {(XLEN+1){1'b0}};
            quo_r     <= ZERO;
            div_r     <= ZERO;
            o_valid_r <= 1'b0;
            o_res_r   <= ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_valid_r <= 1'b0;
                    // Kill wins over a simultaneous request.
                    if (i_valid && !i_kill) begin
                        op_r    <= i_op;
                        neg_q_r <= neg_a_s ^ neg_b_s;
                        neg_r_r <= neg_a_s;
                        if (div_zero_s) begin
                            o_res_r   <= i_op[1] ? i_rs1 : ALL_ONES;
                            o_valid_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end else if (overflow_s) begin
                            o_res_r   <= i_op[1] ? ZERO : INT_MIN;
                            o_valid_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            quo_r   <= mag_a_s;
                            div_r   <= mag_b_s;
                            rem_r   <= {(XLEN+1){1'b0}};
                            cnt_r   <= 5'd0;
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (i_kill) begin
                        o_valid_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        quo_r <= quo_next_s;
                        rem_r <= rem_next_s;
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == 5'd31) begin
                            o_res_r   <= res_fin_s;
                            o_valid_r <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    o_valid_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    o_valid_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (state_r == ST_IDLE);
    assign o_busy  = (state_r != ST_IDLE);
    assign o_valid = o_valid_r;
    assign o_res   = o_res_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, kill/reset
// behaviour and randomized operations against a plain-arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_kill;
    logic        o_ready;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_res;

    int n_vec  = 0;
    int n_miss = 0;

    div_unit dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_op    (i_op),
        .i_rs1   (i_rs1),
        .i_rs2   (i_rs2),
        .i_kill  (i_kill),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_valid (o_valid),
        .o_res   (o_res)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    // Issue one request at the current negedge and check result, latency, pulse width.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        logic [31:0] prev;
        logic [31:0] exp;
        int          lat;
        int          exp_lat;
        prev    = o_res;
        exp     = ref_res(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : 33;
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold) i_valid = 1'b0;
            if (lat == 1 && exp_lat == 33) begin
                check_val("busy", {31'd0, o_busy}, 32'd1);
                check_val("res_hold", o_res, prev);
            end
        end while (!o_valid && lat < 40);
        i_valid = 1'b0;
        check_val("latency", 32'(lat), 32'(exp_lat));
        check_val("result", o_res, exp);
        @(negedge clk);
        check_val("pulse_end", {31'd0, o_valid}, 32'd0);
        check_val("ready_after", {31'd0, o_ready}, 32'd1);
    endtask

    // Count o_valid pulses over a fixed window.
    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (o_valid) pulses++;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int pulses;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_op    = 2'b00;
        i_rs1   = 32'd0;
        i_rs2   = 32'd0;
        i_kill  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, o_ready}, 32'd1);
        check_val("rst_busy", {31'd0, o_busy}, 32'd0);
        check_val("rst_valid", {31'd0, o_valid}, 32'd0);
        check_val("rst_res", o_res, 32'd0);
        i_rst = 1'b0;

        run_op(2'b01, 32'd100, 32'd7, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b00, 32'd5, 32'd0, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

        // Kill during CALC, then a fresh request.
        i_valid = 1'b1; i_op = 2'b01; i_rs1 = 32'd100; i_rs2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (9) @(negedge clk);
        i_kill = 1'b1;
        @(negedge clk);
        i_kill = 1'b0;
        check_val("kill_ready", {31'd0, o_ready}, 32'd1);
        check_val("kill_valid", {31'd0, o_valid}, 32'd0);
        count_pulses(40, pulses);
        check_val("kill_pulses", 32'(pulses), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, 1'b0);

        // Kill and valid together in IDLE: no acceptance.
        i_valid = 1'b1; i_kill = 1'b1; i_op = 2'b01; i_rs1 = 32'd9; i_rs2 = 32'd3;
        @(negedge clk);
        i_valid = 1'b0; i_kill = 1'b0;
        check_val("kill_idle_ready", {31'd0, o_ready}, 32'd1);

        // Request held high while busy yields exactly one result.
        run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        count_pulses(40, pulses);
        check_val("hold_pulses", 32'(pulses), 32'd0);

        // Reset mid-CALC, then accept immediately after release.
        i_valid = 1'b1; i_op = 2'b01; i_rs1 = 32'd77; i_rs2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        check_val("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check_val("mid_rst_res", o_res, 32'd0);
        i_rst = 1'b0;
        run_op(2'b11, 32'd77, 32'd5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
